// File: rtl/led_counter_top.sv
// Up/down LED counter: synchronised enable/dir, prescaled step every DIV cycles, leds driven from the count register.
// First step lands DIV+2 edges after enable is sampled; there is no handshake or backpressure, so leds is valid every cycle.
module led_counter_top #(
  parameter int WIDTH = 4,
  parameter int DIV   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  output logic [WIDTH-1:0] leds
);

  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic             en_m_q, en_m_d;
  logic             en_s_q, en_s_d;
  logic             dir_m_q, dir_m_d;
  logic             dir_s_q, dir_s_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tick;

  always_comb begin
    en_m_d  = enable;
    en_s_d  = en_m_q;
    dir_m_d = dir;
    dir_s_d = dir_m_q;

    // For DIV=1 PRE_LAST is 0 and pre never leaves 0, so tick follows en_s.
    tick = en_s_q && (pre_q == PRE_LAST);

    pre_d = '0;
    if (en_s_q && (pre_q != PRE_LAST)) begin
      pre_d = pre_q + PW'(1);
    end

    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = dir_s_q ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_m_q  <= 1'b0;
      en_s_q  <= 1'b0;
      dir_m_q <= 1'b0;
      dir_s_q <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      en_m_q  <= en_m_d;
      en_s_q  <= en_s_d;
      dir_m_q <= dir_m_d;
      dir_s_q <= dir_s_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign leds = cnt_q;

endmodule

// File: tb/tb_led_counter_top.sv
// Bench for led_counter_top: a WIDTH=4/DIV=5 instance and a WIDTH=3/DIV=1 instance share all inputs.
// Reference model works in terms of enabled-cycle run length and modular arithmetic.
module tb_led_counter_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       dir;
  logic [3:0] leds_a;
  logic [2:0] leds_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_counter_top #(.WIDTH(4), .DIV(5)) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .dir    (dir),
    .leds   (leds_a)
  );

  led_counter_top #(.WIDTH(3), .DIV(1)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .dir    (dir),
    .leds   (leds_b)
  );

  // Reference: inputs become visible two edges after being sampled; a step occurs
  // on every DIV-th consecutive edge seen with the synchronised enable high.
  int en_pipe [2];
  int dir_pipe[2];
  int run;
  int cnt_a;
  int cnt_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_pipe  = '{0, 0};
      dir_pipe = '{0, 0};
      run      = 0;
      cnt_a    = 0;
      cnt_b    = 0;
    end else begin
      if (en_pipe[1] != 0) begin
        if (run % 5 == 4) cnt_a = (dir_pipe[1] != 0) ? (cnt_a + 1) % 16 : (cnt_a + 15) % 16;
        cnt_b = (dir_pipe[1] != 0) ? (cnt_b + 1) % 8 : (cnt_b + 7) % 8;
        run   = run + 1;
      end else begin
        run = 0;
      end
      en_pipe[1]  = en_pipe[0];
      en_pipe[0]  = int'(enable);
      dir_pipe[1] = dir_pipe[0];
      dir_pipe[0] = int'(dir);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n edges, comparing both instances with the model 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("leds_a_model", {28'd0, leds_a}, cnt_a);
      chk("leds_b_model", {29'd0, leds_b}, cnt_b);
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    chk("reset_async_a", {28'd0, leds_a}, 0);
    chk("reset_async_b", {29'd0, leds_b}, 0);
    step(2);
    reset = 1'b1;
  endtask

  int exp_down[5] = '{2, 1, 0, 15, 14};

  initial begin
    reset  = 1'b0;
    enable = 1'b1;
    dir    = 1'b1;
    #1;
    chk("reset_initial", {28'd0, leds_a}, 0);
    step(10);
    chk("reset_held", {28'd0, leds_a}, 0);

    enable = 1'b0;
    reset  = 1'b1;
    step(5);
    chk("release_disabled", {28'd0, leds_a}, 0);

    // Count up: enable set up before E1, steps on E7, E12, E17.
    enable = 1'b1;
    step(6);
    chk("up_before_e7", {28'd0, leds_a}, 0);
    step(1);
    chk("up_e7", {28'd0, leds_a}, 1);
    step(5);
    chk("up_e12", {28'd0, leds_a}, 2);
    step(5);
    chk("up_e17", {28'd0, leds_a}, 3);
    step(65);
    chk("up_wrap", {28'd0, leds_a}, 0);
    step(15);
    chk("up_at3", {28'd0, leds_a}, 3);

    // Count down from 3; next tick is five edges away.
    dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(5);
      chk("down_seq", {28'd0, leds_a}, exp_down[i]);
    end

    // Hold and restart.
    enable = 1'b0;
    step(10);
    chk("hold_frozen", {28'd0, leds_a}, 14);
    enable = 1'b1;
    step(6);
    chk("restart_pre", {28'd0, leds_a}, 14);
    step(1);
    chk("restart_step", {28'd0, leds_a}, 13);

    // Up to 9, then asynchronous reset between edges.
    dir = 1'b1;
    step(60);
    chk("mid_at9", {28'd0, leds_a}, 9);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_reset_async", {28'd0, leds_a}, 0);
    step(3);
    reset = 1'b1;
    step(6);
    chk("post_reset_pre", {28'd0, leds_a}, 0);
    step(1);
    chk("post_reset_step", {28'd0, leds_a}, 1);

    // DIV=1 corner: step every cycle once en_s is high.
    reset_pulse();
    enable = 1'b1;
    dir    = 1'b1;
    step(2);
    chk("div1_idle", {29'd0, leds_b}, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("div1_up", {29'd0, leds_b}, i % 8);
    end
    reset_pulse();
    dir = 1'b0;
    step(2);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk("div1_down", {29'd0, leds_b}, (8 - i) % 8);
    end

    // Randomised enable/dir activity with occasional mid-cycle resets.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset_pulse();
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_counter_top.md
# led_counter_top

Free-running up/down LED counter for board-level bring-up and demonstrations. It synchronises two asynchronous control inputs (`enable`, `dir`) and divides the system clock by a parameterised prescaler. It steps a `WIDTH`-bit modular counter once per prescaler period and drives the count directly onto the LED pins. It sits at the top level between the board clock/reset and the LED outputs.

## Interface
- `WIDTH`, default 4: counter/LED width in bits; ≥1.
- `DIV`, default 5: prescaler period in clock cycles between count steps; ≥1.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0); one clock; release is synchronous to `clk` at board level.
- `enable`  in  1  asynchronous count-enable; 1 = count, 0 = hold.
- `dir`  in  1  asynchronous direction; 1 = up, 0 = down.
- `leds`  out  `WIDTH`  current count value, driven straight from the count register.

## Operation
- Input synchronisers:
  - Two-flop synchroniser on `enable`, giving `en_s`.
  - Two-flop synchroniser on `dir`, giving `dir_s`.
  - All synchroniser flops reset to 0.
- Prescaler register `pre`, width `max(1,$clog2(DIV))`:
  - If `en_s`=0, `pre` is cleared to 0.
  - If `en_s`=1, `pre` increments each cycle and wraps from DIV-1 to 0.
- `tick` = `en_s` && (`pre` == DIV-1), combinational.
  - For DIV=1, `tick` = `en_s`, i.e. a step every enabled cycle.
- Count register `cnt` (`WIDTH` bits):
  - On `tick`, `cnt` ← `cnt`+1 if `dir_s`=1, else `cnt`-1.
  - Arithmetic is modulo 2^WIDTH: up from all-ones wraps to 0; down from 0 wraps to all-ones.
  - Without `tick`, `cnt` holds.
- `leds` = `cnt`; no extra output register and no inversion.
- Deasserting `enable` freezes `leds` at its current value and clears the prescaler. Re-enabling restarts a full DIV-cycle period.
- A change of `dir` does not touch the prescaler. The new direction applies at the first `tick` after `dir_s` updates.
- Reset asserted (`reset`=0) at any time, including mid-count:
  - Immediately clears the synchronisers, `pre` and `cnt`, so `leds`=0, without waiting for a clock.
  - After reset release, counting resumes only through the normal enable path.

## Timing
- Reset value of every output: `leds`=0.
- Synchroniser latency: a change on `enable`/`dir` that is set up before edge E1 appears on `en_s`/`dir_s` after edge E2.
- First step: with `enable` rising before edge E1, `en_s`=1 from E2. `pre` counts 0..DIV-1 on edges E3..E(2+DIV), and `cnt` changes on edge E(2+DIV). For DIV=5 this is edge E7.
- Subsequent steps occur every DIV cycles while `en_s` stays 1.
- Disable latency: `enable` falling before E1 gives `en_s`=0 after E2. A `tick` coinciding with E2 (evaluated with the old `en_s`=1) still takes effect; no step occurs after E2.
- Direction latency: a `dir` change before E1 affects any `tick` on edge E3 or later. A `tick` on E2 or earlier uses the old direction.
- Simultaneous `enable` and `dir` changes are independent; each follows its own 2-cycle path.
- No handshake; `leds` is valid every cycle.

## Test plan
- Reset:
  - Hold `reset`=0 for 10 cycles with `enable`=1 → `leds`=0 throughout.
  - After release with `enable`=0 → `leds` stays 0.
- Count up, WIDTH=4, DIV=5, `dir`=1:
  - `enable` raised before edge E1 → `leds`=1 after E7, 2 after E12, 3 after E17.
  - After 16 steps `leds` wraps 15→0.
- Count down:
  - From `leds`=3, `dir`→0 before an edge with ≥2 cycles margin to the next tick → next steps give 2, 1, 0, 15, 14 at DIV-cycle spacing.
- Enable hold/restart:
  - Drop `enable` → `leds` freezes within 2 cycles plus at most one pending tick.
  - Re-raise `enable` → next step exactly DIV+2 edges later.
- Async reset mid-count:
  - Assert `reset`=0 between clock edges while `leds`=9 → `leds`=0 before the next rising edge.
  - After release, counting restarts with the E(2+DIV) latency.
- Parameter corner, DIV=1, WIDTH=3:
  - `leds` steps every cycle once `en_s`=1: 0,1,…,7,0.
  - With `dir`=0: 0,7,6,….
